// File: rtl/contador_regressivo_7bits_pkg.sv
// Shared types for the 7-bit down-counter:
// FSM state encoding, default load limit and load saturation.
package contador_regressivo_7bits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } estado_t;

  localparam int MAX_LOAD_DEF = 99;

  function automatic logic [6:0] satura(
    input logic [6:0] d,
    input logic [6:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/contador_regressivo_7bits_gerador_tick.sv
// Prescaler: counts 0..PRESCALE-1 while EN, TICK on terminal count.
// Ports: CLK, RST (async high), EN, CLR (sync), TICK (comb strobe).
module gerador_tick #(
  parameter int PRESCALE = 50
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;
  logic         fim;

  assign fim  = (cnt == LAST);
  assign TICK = EN && fim;

  // Compare-to-terminal: never relies on natural wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= fim ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/contador_regressivo_7bits.sv
// Loadable 7-bit down-counter with run/pause/done FSM.
// Ports: CLK, RST, LOAD, DATA, START, PAUSE, MIN_IN -> REG, RUNNING, DONE, TICK.
module contador_regressivo_7bits
  import contador_regressivo_7bits_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int MAX_LOAD = MAX_LOAD_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [6:0] DATA,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       MIN_IN,
  output logic [6:0] REG,
  output logic       RUNNING,
  output logic       DONE,
  output logic       TICK
);

  localparam logic [6:0] LIM = 7'(MAX_LOAD);

  estado_t    st;
  estado_t    st_nxt;
  logic [6:0] reg_nxt;
  logic [6:0] carga;
  logic       tick_nxt;
  logic       pre_en;
  logic       pre_clr;
  logic       pre_fim;

  assign carga = satura(DATA, LIM);

  // PAUSE freezes the prescaler on the same edge it leaves RUN,
  // so a coinciding tick is lost and HOLD keeps the partial count.
  assign pre_en  = (st == ST_RUN) && !PAUSE;
  assign pre_clr = (st == ST_IDLE) || (st == ST_DONE);

  gerador_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .EN  (pre_en),
    .CLR (pre_clr),
    .TICK(pre_fim)
  );

  always_comb begin
    st_nxt   = st;
    reg_nxt  = REG;
    tick_nxt = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (LOAD) begin
          reg_nxt = carga;
        end else if (START && (REG != '0)) begin
          st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (PAUSE) begin
          st_nxt = ST_HOLD;
        end else if (pre_fim) begin
          tick_nxt = 1'b1;
          // REG==0 check keeps the count from wrapping
          // even if the detector never fires.
          if (MIN_IN || (REG == '0)) begin
            st_nxt = ST_DONE;
          end else begin
            reg_nxt = REG - 7'd1;
          end
        end
      end
      ST_HOLD: begin
        if (LOAD) begin
          st_nxt  = ST_IDLE;
          reg_nxt = carga;
        end else if (START) begin
          st_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (LOAD) begin
          st_nxt  = ST_IDLE;
          reg_nxt = carga;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st   <= ST_IDLE;
      REG  <= '0;
      TICK <= 1'b0;
    end else begin
      st   <= st_nxt;
      REG  <= reg_nxt;
      TICK <= tick_nxt;
    end
  end

  assign RUNNING = (st == ST_RUN);
  assign DONE    = (st == ST_DONE);

endmodule

// File: tb/tb_contador_regressivo_7bits.sv
// Bench for contador_regressivo_7bits (PRESCALE=4):
// directed scenarios plus random traffic against a reference model.
module tb_contador_regressivo_7bits;

  localparam int P = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD;
  logic [6:0] DATA;
  logic       START;
  logic       PAUSE;
  logic       MIN_IN;
  logic [6:0] REG;
  logic       RUNNING;
  logic       DONE;
  logic       TICK;

  logic min_en = 1'b0;
  logic mon_on = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  // Detector stand-in: combinational on the live count.
  assign MIN_IN = min_en && (REG <= 7'd5);

  contador_regressivo_7bits #(
    .PRESCALE(P),
    .MAX_LOAD(99)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .LOAD   (LOAD),
    .DATA   (DATA),
    .START  (START),
    .PAUSE  (PAUSE),
    .MIN_IN (MIN_IN),
    .REG    (REG),
    .RUNNING(RUNNING),
    .DONE   (DONE),
    .TICK   (TICK)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model. mode: 0 idle, 1 run, 2 hold, 3 done.
  // ph = cycles elapsed in the current tick period.
  typedef struct {
    int mode;
    int val;
    int ph;
    int tk;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0};

  function automatic int sat(input int d);
    return (d > 99) ? 99 : d;
  endfunction

  function automatic mdl_t step(
    input mdl_t s, input bit ld, input int d,
    input bit go, input bit pa, input bit men
  );
    mdl_t r;
    bit   mf;
    r    = s;
    r.tk = 0;
    mf   = men && (s.val <= 5);
    case (s.mode)
      0: begin
        if (ld) r.val = sat(d);
        else if (go && s.val != 0) begin
          r.mode = 1;
          r.ph   = 0;
        end
      end
      1: begin
        if (pa) r.mode = 2;
        else if (s.ph == P - 1) begin
          r.ph = 0;
          r.tk = 1;
          if (mf || s.val == 0) r.mode = 3;
          else r.val = s.val - 1;
        end else r.ph = s.ph + 1;
      end
      2: begin
        if (ld) begin
          r.mode = 0;
          r.val  = sat(d);
        end else if (go) r.mode = 1;
      end
      default: begin
        if (ld) begin
          r.mode = 0;
          r.val  = sat(d);
        end
      end
    endcase
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= '{0, 0, 0, 0};
    else m <= step(m, LOAD, int'(DATA), START, PAUSE, min_en);
  end

  always @(negedge CLK) begin
    if (mon_on && !RST) begin
      chk("m_reg", int'(REG), m.val);
      chk("m_running", int'(RUNNING), int'(m.mode == 1));
      chk("m_done", int'(DONE), int'(m.mode == 3));
      chk("m_tick", int'(TICK), m.tk);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_load(input int d);
    DATA = 7'(d);
    LOAD = 1'b1;
    cyc(1);
    LOAD = 1'b0;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic async_rst(input string tag);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk({tag, "_reg"}, int'(REG), 0);
    chk({tag, "_run"}, int'(RUNNING), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_tick"}, int'(TICK), 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    RST   = 1'b1;
    LOAD  = 1'b0;
    START = 1'b0;
    PAUSE = 1'b0;
    DATA  = '0;
    #12;
    chk("rst0_reg", int'(REG), 0);
    chk("rst0_run", int'(RUNNING), 0);
    chk("rst0_done", int'(DONE), 0);
    @(negedge CLK);
    RST    = 1'b0;
    mon_on = 1'b1;

    // reset in the middle of a countdown
    do_load(20);
    pulse_start();
    cyc(1);
    chk("pre_rst_reg", int'(REG), 20);
    chk("pre_rst_run", int'(RUNNING), 1);
    async_rst("rst_mid");

    // saturating load
    do_load(120);
    chk("sat_120", int'(REG), 99);
    do_load(42);
    chk("load_42", int'(REG), 42);

    // countdown until the detector fires
    min_en = 1'b1;
    do_load(10);
    pulse_start();
    n     = 0;
    ticks = 0;
    while (!DONE && n < 100) begin
      cyc(1);
      n++;
      if (TICK) ticks++;
    end
    chk("cd_done", int'(DONE), 1);
    chk("cd_reg", int'(REG), 5);
    chk("cd_ticks", ticks, 6);
    cyc(10);
    chk("cd_hold_reg", int'(REG), 5);
    chk("cd_hold_done", int'(DONE), 1);
    do_load(77);
    chk("done_load_reg", int'(REG), 77);
    chk("done_load_done", int'(DONE), 0);
    min_en = 1'b0;

    // pause with prescaler at 2, then resume
    do_load(8);
    pulse_start();
    cyc(2);
    PAUSE = 1'b1;
    cyc(1);
    PAUSE = 1'b0;
    chk("hold_run", int'(RUNNING), 0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_reg", int'(REG), 8);
      chk("hold_tick", int'(TICK), 0);
      cyc(1);
    end
    pulse_start();
    cyc(1);
    chk("resume_r1", int'(REG), 8);
    cyc(1);
    chk("resume_r2", int'(REG), 7);
    chk("resume_tick", int'(TICK), 1);
    async_rst("rst_b");

    // zero guard with the detector silent
    do_load(2);
    pulse_start();
    n = 0;
    while (!DONE && n < 100) begin
      cyc(1);
      n++;
      chk("zg_range", int'(REG <= 7'd2), 1);
    end
    chk("zg_done", int'(DONE), 1);
    chk("zg_reg", int'(REG), 0);
    cyc(8);
    chk("zg_stay", int'(REG), 0);
    do_load(0);
    chk("zg_idle", int'(DONE), 0);
    pulse_start();
    cyc(2);
    chk("zg_nostart", int'(RUNNING), 0);

    // PAUSE on the tick edge, then LOAD+START in HOLD
    do_load(15);
    pulse_start();
    cyc(P - 1);
    PAUSE = 1'b1;
    cyc(1);
    PAUSE = 1'b0;
    chk("pt_reg", int'(REG), 15);
    chk("pt_tick", int'(TICK), 0);
    chk("pt_run", int'(RUNNING), 0);
    DATA  = 7'd33;
    LOAD  = 1'b1;
    START = 1'b1;
    cyc(1);
    LOAD  = 1'b0;
    START = 1'b0;
    chk("ls_reg", int'(REG), 33);
    chk("ls_run", int'(RUNNING), 0);
    chk("ls_done", int'(DONE), 0);
    cyc(2);
    chk("ls_idle", int'(RUNNING), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      LOAD  = ($urandom % 12) == 0;
      DATA  = ($urandom % 4 == 0) ? 7'($urandom)
                                  : 7'($urandom_range(0, 12));
      START = ($urandom % 4) == 0;
      PAUSE = ($urandom % 9) == 0;
      if ($urandom % 64 == 0) min_en = ~min_en;
      if ($urandom % 600 == 0) async_rst("rst_rnd");
      else cyc(1);
    end
    LOAD  = 1'b0;
    START = 1'b0;
    PAUSE = 1'b0;
    cyc(2);
    mon_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
